// File: rtl/vga_scan_gen_if.sv
// rtl/vga_scan_gen_if.sv - scan coordinates, draw-block feedback and VGA outputs
//
// Bundles everything exchanged between the raster scan generator (master)
// and its consumers: draw blocks plus the VGA connector (slave).
//   x, y         scan coordinates, 10 bits each
//   pixel_tick   one-clk strobe per pixel period
//   video_on     visible-area flag for the current x/y
//   frame_start  one-clk pulse on the last pixel of a frame
//   hsync, vsync active-low registered syncs
//   rgb          registered {R4,G4,B4} colour
//   pixel_on     ORed draw-block display flag for the current x/y
//   fg_rgb       colour shown where pixel_on=1
//   bg_rgb       colour shown where pixel_on=0 in the visible area
interface vga_scan_gen_if;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        pixel_tick;
    logic        video_on;
    logic        frame_start;
    logic        hsync;
    logic        vsync;
    logic [11:0] rgb;
    logic        pixel_on;
    logic [11:0] fg_rgb;
    logic [11:0] bg_rgb;

    modport master (
        output x, y, pixel_tick, video_on, frame_start, hsync, vsync, rgb,
        input  pixel_on, fg_rgb, bg_rgb
    );

    modport slave (
        input  x, y, pixel_tick, video_on, frame_start, hsync, vsync, rgb,
        output pixel_on, fg_rgb, bg_rgb
    );
endinterface

// File: rtl/vga_scan_gen.sv
// rtl/vga_scan_gen.sv - raster scan generator with registered colour and sync stage
//
// Divides clk down to a pixel strobe, walks h/v counters over the full
// raster, exposes them as x/y to the draw blocks, and registers the colour
// chosen from their pixel_on feedback together with hsync/vsync so all three
// leave one pixel period after the counters that produced them.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    vga_scan_gen_if.master (x, y, pixel_tick, video_on, frame_start,
//          hsync, vsync, rgb out; pixel_on, fg_rgb, bg_rgb in)
module vga_scan_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int CLK_DIV   = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    vga_scan_gen_if.master bus
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC);

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_q, tick_d;
    logic [9:0]       h_count_q, h_count_d;
    logic [9:0]       v_count_q, v_count_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic [11:0]      rgb_q, rgb_d;

    logic video_on;
    logic hsync_raw;
    logic vsync_raw;
    logic h_last;
    logic v_last;

    assign h_last    = (h_count_q == H_LAST);
    assign v_last    = (v_count_q == V_LAST);
    assign video_on  = (h_count_q < H_VIS) && (v_count_q < V_VIS);
    // Sync windows are half-open: [start, end)
    assign hsync_raw = !((h_count_q >= HS_START) && (h_count_q < HS_END));
    assign vsync_raw = !((v_count_q >= VS_START) && (v_count_q < VS_END));

    always_comb begin
        div_d     = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        // Registered so the strobe is high during the last clk of a pixel
        // period; everything below advances on the edge that ends it.
        tick_d    = (div_q == DIV_LAST);
        h_count_d = h_count_q;
        v_count_d = v_count_q;
        hsync_d   = hsync_q;
        vsync_d   = vsync_q;
        rgb_d     = rgb_q;
        if (tick_q) begin
            if (h_last) begin
                h_count_d = '0;
                v_count_d = v_last ? '0 : v_count_q + 10'd1;
            end else begin
                h_count_d = h_count_q + 10'd1;
            end
            // Output stage captures the period that is ending, so colour
            // and syncs stay aligned one pixel behind the counters.
            rgb_d   = video_on ? (bus.pixel_on ? bus.fg_rgb : bus.bg_rgb) : 12'h000;
            hsync_d = hsync_raw;
            vsync_d = vsync_raw;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q     <= '0;
            tick_q    <= 1'b0;
            h_count_q <= '0;
            v_count_q <= '0;
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
            rgb_q     <= 12'h000;
        end else begin
            div_q     <= div_d;
            tick_q    <= tick_d;
            h_count_q <= h_count_d;
            v_count_q <= v_count_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            rgb_q     <= rgb_d;
        end
    end

    assign bus.x           = h_count_q;
    assign bus.y           = v_count_q;
    assign bus.pixel_tick  = tick_q;
    assign bus.video_on    = video_on;
    assign bus.frame_start = tick_q & h_last & v_last;
    assign bus.hsync       = hsync_q;
    assign bus.vsync       = vsync_q;
    assign bus.rgb         = rgb_q;

endmodule

// File: tb/tb_vga_scan_gen.sv
// tb/tb_vga_scan_gen.sv - self-checking bench for vga_scan_gen on a reduced raster
module tb_vga_scan_gen;

    localparam int HD  = 16;
    localparam int HF  = 2;
    localparam int HS  = 3;
    localparam int HB  = 3;
    localparam int HT  = HD + HF + HS + HB;
    localparam int VD  = 6;
    localparam int VF  = 1;
    localparam int VS  = 2;
    localparam int VB  = 1;
    localparam int VT  = VD + VF + VS + VB;
    localparam int DIV = 4;
    localparam int TX  = 10;
    localparam int TY  = 3;
    localparam logic [11:0] FG = 12'hF00;
    localparam logic [11:0] BG = 12'h00F;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    vga_scan_gen_if vif ();

    vga_scan_gen #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .CLK_DIV(DIV)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (vif)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] rgb;
        logic        hs;
        logic        vs;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   mc, mx, my;
    logic was_tick;
    int   tick_cnt, hs_low, vs_low, fg_cnt, fs_cnt, max_x;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        cur      = '{rgb: 12'h000, hs: 1'b1, vs: 1'b1};
        mc       = 0;
        mx       = 0;
        my       = 0;
        was_tick = 1'b0;
    endtask

    task automatic clear_counts();
        tick_cnt = 0;
        hs_low   = 0;
        vs_low   = 0;
        fg_cnt   = 0;
        fs_cnt   = 0;
        max_x    = 0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_x"},           vif.x, 0);
        chk({tag, "_y"},           vif.y, 0);
        chk({tag, "_hsync"},       vif.hsync, 1);
        chk({tag, "_vsync"},       vif.vsync, 1);
        chk({tag, "_rgb"},         vif.rgb, 0);
        chk({tag, "_pixel_tick"},  vif.pixel_tick, 0);
        chk({tag, "_frame_start"}, vif.frame_start, 0);
        chk({tag, "_video_on"},    vif.video_on, 1);
    endtask

    // One clock: sample after the edge, compare against the model, then drive
    // inputs for the next edge. Defined inputs only on tick cycles; random
    // junk otherwise, which must never reach the outputs.
    task automatic step();
        logic exp_tick, vis, last;
        exp_t e;
        @(posedge clk);
        #1;
        mc++;
        if (was_tick) begin
            if (mx == HT - 1) begin
                mx = 0;
                my = (my == VT - 1) ? 0 : my + 1;
            end else begin
                mx++;
            end
            if (sb.size() == 0) chk("scoreboard_underflow", 0, 1);
            else cur = sb.pop_front();
            if (!vif.hsync) hs_low++;
            if (!vif.vsync) vs_low++;
            if (vif.rgb == FG) fg_cnt++;
        end
        chk("rgb",   vif.rgb,   cur.rgb);
        chk("hsync", vif.hsync, cur.hs);
        chk("vsync", vif.vsync, cur.vs);
        exp_tick = (mc % DIV == 0);
        chk("pixel_tick", vif.pixel_tick, exp_tick);
        chk("x", vif.x, mx);
        chk("y", vif.y, my);
        vis = (mx < HD) && (my < VD);
        chk("video_on", vif.video_on, vis);
        last = exp_tick && (mx == HT - 1) && (my == VT - 1);
        chk("frame_start", vif.frame_start, last);
        if (vif.pixel_tick) tick_cnt++;
        if (vif.frame_start) fs_cnt++;
        if (int'(vif.x) > max_x) max_x = int'(vif.x);
        if (exp_tick) begin
            vif.pixel_on = ((mx == TX) && (my == TY)) || !vis;
            vif.fg_rgb   = FG;
            vif.bg_rgb   = BG;
            e.rgb = !vis ? 12'h000 : (vif.pixel_on ? FG : BG);
            e.hs  = !((mx >= HD + HF) && (mx < HD + HF + HS));
            e.vs  = !((my >= VD + VF) && (my < VD + VF + VS));
            sb.push_back(e);
        end else begin
            vif.pixel_on = 1'($urandom);
            vif.fg_rgb   = 12'($urandom);
            vif.bg_rgb   = 12'($urandom);
        end
        was_tick = exp_tick;
    endtask

    initial begin
        vif.pixel_on = 1'b0;
        vif.fg_rgb   = FG;
        vif.bg_rgb   = BG;
        model_reset();
        clear_counts();

        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset_initial");

        // Release and check the 40-clk cadence (first tick 4 clks later).
        rst_n = 1'b1;
        model_reset();
        clear_counts();
        repeat (40) step();
        chk("ticks_in_40_clks", tick_cnt, 10);

        // Advance into the horizontal sync pulse, then reset without a clock.
        for (int i = 0; i < 400 && mx != HD + HF + 1; i++) step();
        chk("reached_hsync_region", mx, HD + HF + 1);
        chk("hsync_low_before_reset", vif.hsync, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("reset_async");
        @(posedge clk);
        #1;
        check_reset_state("reset_held");

        // Restart and scan one full frame, plus the output lag of one pixel.
        rst_n = 1'b1;
        model_reset();
        clear_counts();
        repeat (HT * VT * DIV + DIV) step();
        chk("frame1_hsync_low_periods", hs_low, HS * VT);
        chk("frame1_vsync_low_periods", vs_low, VS * HT);
        chk("frame1_fg_pixels", fg_cnt, 1);
        chk("frame1_frame_start_pulses", fs_cnt, 1);
        chk("frame1_max_x", max_x, HT - 1);

        // Second frame through the wrap.
        repeat (HT * VT * DIV) step();
        chk("frame2_hsync_low_periods", hs_low, 2 * HS * VT);
        chk("frame2_vsync_low_periods", vs_low, 2 * VS * HT);
        chk("frame2_fg_pixels", fg_cnt, 2);
        chk("frame2_frame_start_pulses", fs_cnt, 2);
        chk("frame2_max_x", max_x, HT - 1);
        chk("frame2_ticks", tick_cnt, 2 * HT * VT + 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
